// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: drives one column low at a time, debounces press
// and release on the synchronized rows, and reports one key_valid per press.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV        = 4096,
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] DB_LAST    = BW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        SCAN       = 2'd0,
        DB_PRESS   = 2'd1,
        HELD       = 2'd2,
        DB_RELEASE = 2'd3
    } state_t;

    state_t        state_reg, state_next;
    logic [1:0]    col_idx_reg, col_idx_next;
    logic [1:0]    row_idx_reg, row_idx_next;
    logic [DW-1:0] dwell_reg, dwell_next;
    logic [BW-1:0] db_cnt_reg, db_cnt_next;
    logic [3:0]    key_code_reg, key_code_next;
    logic          key_valid_reg, key_valid_next;
    logic          key_held_reg;
    logic [3:0]    cols_reg;
    logic [3:0]    rs_meta_reg, rs_reg;

    logic [1:0]    first_low;
    logic          row_high;

    // Lowest-index low row wins when several rows are pulled down together.
    always_comb begin
        first_low = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rs_reg[i]) begin
                first_low = 2'(i);
            end
        end
    end

    assign row_high = rs_reg[row_idx_reg];

    always_comb begin
        state_next     = state_reg;
        col_idx_next   = col_idx_reg;
        row_idx_next   = row_idx_reg;
        dwell_next     = dwell_reg;
        db_cnt_next    = db_cnt_reg;
        key_code_next  = key_code_reg;
        key_valid_next = 1'b0;
        case (state_reg)
            SCAN: begin
                if (dwell_reg == DWELL_LAST) begin
                    if (rs_reg != 4'b1111) begin
                        row_idx_next = first_low;
                        db_cnt_next  = '0;
                        state_next   = DB_PRESS;
                    end else begin
                        col_idx_next = col_idx_reg + 2'd1;
                        dwell_next   = '0;
                    end
                end else begin
                    dwell_next = dwell_reg + DW'(1);
                end
            end
            DB_PRESS: begin
                if (row_high) begin
                    col_idx_next = col_idx_reg + 2'd1;
                    dwell_next   = '0;
                    state_next   = SCAN;
                end else if (db_cnt_reg == DB_LAST) begin
                    key_code_next  = {row_idx_reg, col_idx_reg};
                    key_valid_next = 1'b1;
                    state_next     = HELD;
                end else begin
                    db_cnt_next = db_cnt_reg + BW'(1);
                end
            end
            HELD: begin
                if (row_high) begin
                    db_cnt_next = '0;
                    state_next  = DB_RELEASE;
                end
            end
            DB_RELEASE: begin
                // A low sample before the terminal count is a release glitch.
                if (!row_high) begin
                    state_next = HELD;
                end else if (db_cnt_reg == DB_LAST) begin
                    col_idx_next = col_idx_reg + 2'd1;
                    dwell_next   = '0;
                    state_next   = SCAN;
                end else begin
                    db_cnt_next = db_cnt_reg + BW'(1);
                end
            end
            default: state_next = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= SCAN;
            col_idx_reg   <= 2'd0;
            row_idx_reg   <= 2'd0;
            dwell_reg     <= '0;
            db_cnt_reg    <= '0;
            key_code_reg  <= 4'h0;
            key_valid_reg <= 1'b0;
            key_held_reg  <= 1'b0;
            cols_reg      <= 4'b1110;
            rs_meta_reg   <= 4'b1111;
            rs_reg        <= 4'b1111;
        end else begin
            state_reg     <= state_next;
            col_idx_reg   <= col_idx_next;
            row_idx_reg   <= row_idx_next;
            dwell_reg     <= dwell_next;
            db_cnt_reg    <= db_cnt_next;
            key_code_reg  <= key_code_next;
            key_valid_reg <= key_valid_next;
            key_held_reg  <= (state_next == HELD) || (state_next == DB_RELEASE);
            cols_reg      <= ~(4'b0001 << col_idx_next);
            rs_meta_reg   <= rows;
            rs_reg        <= rs_meta_reg;
        end
    end

    assign cols      = cols_reg;
    assign key_code  = key_code_reg;
    assign key_valid = key_valid_reg;
    assign key_held  = key_held_reg;

endmodule
